// File: rtl/ptcalc_scheduler.sv
// Round-robin front end for a single pT-calc core: one holding slot per track
// thread, launch/wait handshake with the core, registered result and timeout guard.
`timescale 1ns/1ps
module ptcalc_scheduler #(
  parameter int N_THR       = 3,
  parameter int TIMEOUT_CYC = 64,
  parameter int PL_W        = 24,
  parameter int SF_W        = 12,
  parameter int RES_W       = 16
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  input  logic [N_THR-1:0]        req_valid,
  output logic [N_THR-1:0]        req_ready,
  input  logic [N_THR*PL_W-1:0]   req_pl,
  input  logic [N_THR*SF_W-1:0]   req_sf_inn,
  input  logic [N_THR*SF_W-1:0]   req_sf_mid,
  input  logic [N_THR*SF_W-1:0]   req_sf_out,
  input  logic [N_THR-1:0]        req_c_side,
  output logic                    core_start,
  input  logic                    core_ready,
  input  logic                    core_done,
  output logic [PL_W-1:0]         core_pl,
  output logic [SF_W-1:0]         core_sf_inn,
  output logic [SF_W-1:0]         core_sf_mid,
  output logic [SF_W-1:0]         core_sf_out,
  output logic                    core_c_side,
  input  logic [RES_W-1:0]        core_res,
  input  logic                    core_res_vld,
  output logic                    res_valid,
  output logic [1:0]              res_thr,
  output logic [RES_W-1:0]        res_data,
  output logic                    err_timeout,
  input  logic                    err_clr,
  output logic [15:0]             launch_cnt
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [1:0]       r_rst_sync;
  logic             w_rst_n;
  logic [1:0]       r_state;
  logic [N_THR-1:0] r_pending;
  logic [1:0]       r_rr_ptr;
  logic [1:0]       r_cur_thr;
  logic [TW-1:0]    r_tmo_cnt;
  logic [15:0]      r_launch_cnt;
  logic             r_res_valid;
  logic [1:0]       r_res_thr;
  logic [RES_W-1:0] r_res_data;
  logic             r_err;
  logic [PL_W-1:0]  r_core_pl;
  logic [SF_W-1:0]  r_core_sf_inn, r_core_sf_mid, r_core_sf_out;
  logic             r_core_c_side;

  logic [PL_W-1:0]  r_slot_pl     [N_THR];
  logic [SF_W-1:0]  r_slot_sf_inn [N_THR];
  logic [SF_W-1:0]  r_slot_sf_mid [N_THR];
  logic [SF_W-1:0]  r_slot_sf_out [N_THR];
  logic             r_slot_c_side [N_THR];

  logic [N_THR-1:0] w_capture;
  logic [N_THR-1:0] w_clr;
  logic [2:0]       w_pick;
  logic             w_do_grant;
  logic [1:0]       w_grant;
  logic [1:0]       w_rr_next;
  logic             w_tmo_set;

  // First pending thread at or after ptr, wrapping; {found, index}.
  function automatic logic [2:0] f_pick(input logic [N_THR-1:0] pend, input logic [1:0] ptr);
    logic [2:0] pick;
    logic [1:0] sel;
    int         idx;
    pick = 3'b000;
    for (int k = N_THR - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N_THR;
      sel = 2'(idx);
      if (pend[sel]) pick = {1'b1, sel};
    end
    return pick;
  endfunction

  // Reset asserts immediately but releases only on a clock edge.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) r_rst_sync <= 2'b00;
    else           r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  assign w_capture = req_valid & ~r_pending;
  assign w_rr_next = (w_grant == 2'(N_THR - 1)) ? 2'd0 : w_grant + 2'd1;
  assign w_tmo_set = (r_state == S_WAIT) && !core_done && (r_tmo_cnt == TW'(TIMEOUT_CYC - 1));

  always_comb begin
    w_pick     = f_pick(r_pending, r_rr_ptr);
    w_do_grant = (r_state == S_IDLE) && w_pick[2];
    w_grant    = w_pick[1:0];
    w_clr      = '0;
    if (w_do_grant) w_clr[w_grant] = 1'b1;
  end

  // Slot payloads are only meaningful while pending, so they carry no reset.
  always_ff @(posedge ap_clk) begin
    for (int i = 0; i < N_THR; i++) begin
      if (w_capture[i]) begin
        r_slot_pl[i]     <= req_pl[i*PL_W +: PL_W];
        r_slot_sf_inn[i] <= req_sf_inn[i*SF_W +: SF_W];
        r_slot_sf_mid[i] <= req_sf_mid[i*SF_W +: SF_W];
        r_slot_sf_out[i] <= req_sf_out[i*SF_W +: SF_W];
        r_slot_c_side[i] <= req_c_side[i];
      end
    end
  end

  always_ff @(posedge ap_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state       <= S_IDLE;
      r_pending     <= '0;
      r_rr_ptr      <= '0;
      r_cur_thr     <= '0;
      r_tmo_cnt     <= '0;
      r_launch_cnt  <= '0;
      r_res_valid   <= 1'b0;
      r_res_thr     <= '0;
      r_res_data    <= '0;
      r_err         <= 1'b0;
      r_core_pl     <= '0;
      r_core_sf_inn <= '0;
      r_core_sf_mid <= '0;
      r_core_sf_out <= '0;
      r_core_c_side <= 1'b0;
    end else begin
      r_pending   <= (r_pending & ~w_clr) | w_capture;
      r_res_valid <= 1'b0;
      if (w_tmo_set)    r_err <= 1'b1;
      else if (err_clr) r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_do_grant) begin
            r_core_pl     <= r_slot_pl[w_grant];
            r_core_sf_inn <= r_slot_sf_inn[w_grant];
            r_core_sf_mid <= r_slot_sf_mid[w_grant];
            r_core_sf_out <= r_slot_sf_out[w_grant];
            r_core_c_side <= r_slot_c_side[w_grant];
            r_cur_thr     <= w_grant;
            r_rr_ptr      <= w_rr_next;
            r_state       <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          if (core_ready) begin
            r_launch_cnt <= r_launch_cnt + 16'd1;
            r_tmo_cnt    <= '0;
            r_state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (core_res_vld) begin
            r_res_valid <= 1'b1;
            r_res_data  <= core_res;
            r_res_thr   <= r_cur_thr;
          end
          if (core_done || w_tmo_set) r_state <= S_IDLE;
          else                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready   = ~r_pending;
  assign core_start  = (r_state == S_LAUNCH);
  assign core_pl     = r_core_pl;
  assign core_sf_inn = r_core_sf_inn;
  assign core_sf_mid = r_core_sf_mid;
  assign core_sf_out = r_core_sf_out;
  assign core_c_side = r_core_c_side;
  assign res_valid   = r_res_valid;
  assign res_thr     = r_res_thr;
  assign res_data    = r_res_data;
  assign err_timeout = r_err;
  assign launch_cnt  = r_launch_cnt;

endmodule

// File: tb/tb_ptcalc_scheduler.sv
// Bench for ptcalc_scheduler: directed handshake/timeout/reset sequences, a
// grant-order vector table and a randomized run against a transaction scoreboard.
`timescale 1ns/1ps
module tb_ptcalc_scheduler;
  localparam int N_THR = 3, TMO = 64, PL_W = 24, SF_W = 12, RES_W = 16;

  logic                  ap_clk = 1'b0, ap_rst_n = 1'b0;
  logic [N_THR-1:0]      req_valid = '0, req_ready, req_c_side = '0;
  logic [N_THR*PL_W-1:0] req_pl = '0;
  logic [N_THR*SF_W-1:0] req_sf_inn = '0, req_sf_mid = '0, req_sf_out = '0;
  logic                  core_start, core_ready = 1'b0, core_done = 1'b0, core_res_vld = 1'b0;
  logic [PL_W-1:0]       core_pl;
  logic [SF_W-1:0]       core_sf_inn, core_sf_mid, core_sf_out;
  logic                  core_c_side;
  logic [RES_W-1:0]      core_res = '0, res_data;
  logic                  res_valid, err_timeout, err_clr = 1'b0;
  logic [1:0]            res_thr;
  logic [15:0]           launch_cnt;

  ptcalc_scheduler #(.N_THR(N_THR), .TIMEOUT_CYC(TMO), .PL_W(PL_W), .SF_W(SF_W), .RES_W(RES_W)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_pl(req_pl), .req_sf_inn(req_sf_inn), .req_sf_mid(req_sf_mid), .req_sf_out(req_sf_out),
    .req_c_side(req_c_side), .core_start(core_start), .core_ready(core_ready), .core_done(core_done),
    .core_pl(core_pl), .core_sf_inn(core_sf_inn), .core_sf_mid(core_sf_mid), .core_sf_out(core_sf_out),
    .core_c_side(core_c_side), .core_res(core_res), .core_res_vld(core_res_vld), .res_valid(res_valid),
    .res_thr(res_thr), .res_data(res_data), .err_timeout(err_timeout), .err_clr(err_clr),
    .launch_cnt(launch_cnt));

  always #5 ap_clk = ~ap_clk;

  typedef struct packed {
    logic [PL_W-1:0] pl;
    logic [SF_W-1:0] si, sm, so;
    logic            c;
  } pay_t;

  typedef struct {
    logic [2:0] mask;
    int         n;
    logic [5:0] ord;
  } vec_t;

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s", nm);
  endtask

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  function automatic pay_t mkpay(input int t);
    pay_t p;
    p.pl = PL_W'({$urandom(), 2'(t)});
    p.si = SF_W'($urandom());
    p.sm = SF_W'($urandom());
    p.so = SF_W'($urandom());
    p.c  = 1'($urandom());
    return p;
  endfunction

  function automatic logic [RES_W-1:0] res_f(input pay_t p);
    return RES_W'(p.pl ^ PL_W'(p.si) ^ PL_W'({p.sm, 3'b0}) ^ PL_W'({p.so, 6'b0}) ^ PL_W'(p.c));
  endfunction

  task automatic drive_pay(input int t, input pay_t p);
    req_pl[t*PL_W +: PL_W]     = p.pl;
    req_sf_inn[t*SF_W +: SF_W] = p.si;
    req_sf_mid[t*SF_W +: SF_W] = p.sm;
    req_sf_out[t*SF_W +: SF_W] = p.so;
    req_c_side[t]              = p.c;
  endtask

  task automatic do_reset();
    ap_rst_n = 1'b0;
    step();
    step();
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    repeat (3) step();
  endtask

  task automatic wait_start();
    int w;
    w = 0;
    while (!core_start && w < 20) begin
      step();
      w++;
    end
    chk("start_seen", core_start, 1);
  endtask

  // Play the core for one launch: stall ready, then finish after done_dly cycles.
  task automatic serve(input int rdy_dly, input int done_dly, input logic vld, input int exp_thr,
                       input logic [2:0] side, output logic [PL_W-1:0] got);
    logic [15:0]      lc;
    logic [RES_W-1:0] r;
    got = '0;
    wait_start();
    if (!core_start) return;
    got = core_pl;
    lc  = launch_cnt;
    for (int k = 0; k < rdy_dly; k++) begin
      step();
      chk("start_held", core_start, 1);
      chk("ops_stable_launch", core_pl, got);
    end
    core_ready = 1'b1;
    step();
    core_ready = 1'b0;
    chk("start_drop", core_start, 0);
    chk("launch_inc", launch_cnt, 16'(lc + 16'd1));
    for (int k = 1; k < done_dly; k++) begin
      if (k == 1) req_valid = req_valid | side;
      step();
      req_valid = req_valid & ~side;
      chk("ops_stable_wait", core_pl, got);
    end
    r = RES_W'($urandom());
    core_done = 1'b1; core_res_vld = vld; core_res = r;
    step();
    core_done = 1'b0; core_res_vld = 1'b0; core_res = '0;
    chk("res_valid", res_valid, vld);
    if (vld) begin
      chk("res_thr", res_thr, exp_thr[1:0]);
      chk("res_data", res_data, r);
    end
    step();
    chk("res_pulse", res_valid, 0);
  endtask

  task automatic tmo_run(input int t, input logic hold_clr);
    pay_t p;
    p = mkpay(t);
    drive_pay(t, p);
    req_valid = '0;
    req_valid[t] = 1'b1;
    step();
    req_valid = '0;
    wait_start();
    core_ready = 1'b1;
    err_clr = hold_clr;
    step();
    core_ready = 1'b0;
    for (int k = 1; k < TMO; k++) step();
    chk("tmo_before", err_timeout, 0);
    step();
    chk("tmo_set", err_timeout, 1);
    chk("tmo_idle_start", core_start, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    pay_t             pa, pb, px, pays [N_THR];
    logic [PL_W-1:0]  got;
    vec_t             vt [10];
    pay_t             sb [$];
    logic [RES_W+1:0] expq [$];
    logic [RES_W+1:0] e;
    pay_t             ops, pn;
    logic [RES_W-1:0] acc_res;
    logic             acc_vld;
    int               cs, cd, found;

    // Reset state
    step();
    step();
    chk("rst_ready", req_ready, 3'b111);
    chk("rst_start", core_start, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_lc", launch_cnt, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_core_pl", core_pl, 0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    repeat (3) step();

    // Single request on thread 1
    pa = mkpay(1);
    drive_pay(1, pa);
    req_valid = 3'b010;
    step();
    req_valid = '0;
    chk("r21_ready", req_ready, 3'b101);
    serve(0, 5, 1'b1, 1, 3'b000, got);
    chk("r21_pl", got, pa.pl);
    chk("r21_lc", launch_cnt, 1);
    chk("r21_ready_back", req_ready, 3'b111);

    // Thread 0 held valid while pending: first payload wins (rr now 2)
    px = mkpay(2); pa = mkpay(0); pb = mkpay(0);
    drive_pay(2, px); drive_pay(0, pa);
    req_valid = 3'b101;
    step();
    req_valid = 3'b001;
    drive_pay(0, pb);
    serve(0, 3, 1'b1, 2, 3'b000, got);
    chk("r25_thr2", got, px.pl);
    serve(0, 2, 1'b1, 0, 3'b000, got);
    req_valid = '0;
    chk("r25_first", got, pa.pl);
    serve(0, 2, 1'b1, 0, 3'b000, got);
    chk("r25_second", got, pb.pl);

    // Core stalls ready for 4 cycles
    px = mkpay(2);
    drive_pay(2, px);
    req_valid = 3'b100;
    step();
    req_valid = '0;
    serve(4, 2, 1'b1, 2, 3'b000, got);
    chk("r23_pl", got, px.pl);

    // Timeout, late result ignored, clear; then set-vs-clear collision
    tmo_run(1, 1'b0);
    core_res_vld = 1'b1; core_res = 16'hBEEF;
    step();
    core_res_vld = 1'b0;
    chk("tmo_late_vld", res_valid, 0);
    chk("tmo_sticky", err_timeout, 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("tmo_clr", err_timeout, 0);
    tmo_run(0, 1'b1);
    step();
    chk("tmo_clr_after_set", err_timeout, 0);
    err_clr = 1'b0;

    // Reset while waiting on the core with another thread pending
    drive_pay(1, mkpay(1)); drive_pay(2, mkpay(2));
    req_valid = 3'b110;
    step();
    req_valid = '0;
    wait_start();
    core_ready = 1'b1;
    step();
    core_ready = 1'b0;
    step();
    #2 ap_rst_n = 1'b0;
    #1;
    chk("r26_ready", req_ready, 3'b111);
    chk("r26_start", core_start, 0);
    chk("r26_lc", launch_cnt, 0);
    chk("r26_res_valid", res_valid, 0);
    chk("r26_res", {res_thr, res_data}, 0);
    chk("r26_ops", {core_pl, core_sf_inn, core_c_side}, 0);
    core_done = 1'b1; core_res_vld = 1'b1; core_res = 16'h1234;
    step();
    step();
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("r26_no_res", res_valid, 0);
      chk("r26_no_start", core_start, 0);
    end
    core_done = 1'b0; core_res_vld = 1'b0; core_res = '0;

    // All threads at once after reset, then 0 and 1 re-request while 2 waits
    do_reset();
    for (int t = 0; t < N_THR; t++) begin pays[t] = mkpay(t); drive_pay(t, pays[t]); end
    req_valid = 3'b111;
    step();
    req_valid = '0;
    serve(0, 1, 1'b1, 0, 3'b000, got); chk("r22_g0", got, pays[0].pl);
    serve(0, 1, 1'b1, 1, 3'b000, got); chk("r22_g1", got, pays[1].pl);
    pa = mkpay(0); pb = mkpay(1);
    drive_pay(0, pa); drive_pay(1, pb);
    serve(0, 3, 1'b1, 2, 3'b011, got); chk("r22_g2", got, pays[2].pl);
    serve(0, 1, 1'b1, 0, 3'b000, got); chk("r22_wrap0", got, pa.pl);
    serve(0, 1, 1'b1, 1, 3'b000, got); chk("r22_wrap1", got, pb.pl);

    // Grant-order table; rr pointer carries from row to row starting at 0
    vt[0] = '{3'b111, 3, {2'd2, 2'd1, 2'd0}};
    vt[1] = '{3'b110, 2, {2'd0, 2'd2, 2'd1}};
    vt[2] = '{3'b101, 2, {2'd0, 2'd2, 2'd0}};
    vt[3] = '{3'b011, 2, {2'd0, 2'd1, 2'd0}};
    vt[4] = '{3'b011, 2, {2'd0, 2'd1, 2'd0}};
    vt[5] = '{3'b100, 1, {2'd0, 2'd0, 2'd2}};
    vt[6] = '{3'b110, 2, {2'd0, 2'd2, 2'd1}};
    vt[7] = '{3'b010, 1, {2'd0, 2'd0, 2'd1}};
    vt[8] = '{3'b101, 2, {2'd0, 2'd0, 2'd2}};
    vt[9] = '{3'b111, 3, {2'd0, 2'd2, 2'd1}};
    do_reset();
    for (int v = 0; v < 10; v++) begin
      for (int t = 0; t < N_THR; t++) begin
        pays[t] = mkpay(t);
        if (vt[v].mask[t]) drive_pay(t, pays[t]);
      end
      req_valid = vt[v].mask;
      step();
      req_valid = '0;
      for (int k = 0; k < vt[v].n; k++) begin
        int et;
        et = int'(vt[v].ord[2*k +: 2]);
        serve(0, 1 + k, 1'b1, et, 3'b000, got);
        chk("tbl_grant", got[1:0], vt[v].ord[2*k +: 2]);
        chk("tbl_pl", got, pays[et].pl);
      end
      chk("tbl_drain", req_ready, 3'b111);
    end

    // Randomized traffic against a per-thread scoreboard
    cs = 0; cd = 0; acc_vld = 1'b0; acc_res = '0; ops = '0;
    for (int cyc = 0; cyc < 3200; cyc++) begin
      if (res_valid) begin
        if (expq.size() == 0) chk("rnd_spurious_res", res_valid, 0);
        else begin
          e = expq.pop_front();
          chk("rnd_res", {res_thr, res_data}, e);
        end
      end
      core_done = 1'b0; core_res_vld = 1'b0; core_ready = 1'b0;
      if (cs == 0) begin
        if (core_start && $urandom_range(2) != 0) begin
          core_ready = 1'b1;
          ops = {core_pl, core_sf_inn, core_sf_mid, core_sf_out, core_c_side};
          found = -1;
          for (int j = 0; j < sb.size(); j++) begin
            if (found < 0 && sb[j].pl[1:0] == ops.pl[1:0]) found = j;
          end
          if (found < 0) fail("rnd_unknown_launch");
          else begin
            chk("rnd_ops", ops, sb[found]);
            sb.delete(found);
          end
          acc_res = res_f(ops);
          acc_vld = ($urandom_range(5) != 0);
          cd = $urandom_range(5, 1);
          cs = 1;
        end
      end else begin
        cd--;
        if (cd == 0) begin
          core_done = 1'b1; core_res_vld = acc_vld; core_res = acc_res;
          if (acc_vld) expq.push_back({ops.pl[1:0], acc_res});
          cs = 0;
        end
      end
      for (int t = 0; t < N_THR; t++) begin
        pn = mkpay(t);
        drive_pay(t, pn);
        req_valid[t] = (cyc < 3000) && ($urandom_range(3) == 0);
        if (req_valid[t] && req_ready[t]) sb.push_back(pn);
      end
      step();
    end
    chk("rnd_sb_empty", sb.size(), 0);
    chk("rnd_exp_empty", expq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
